// File: rtl/uart_receiver.sv
// 16x-oversampled 8N1 UART receiver feeding a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_error.
module uart_receiver #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       parity_error,
    output logic [2:0] fsm_state
);

    localparam int DIV     = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV_EFF = (DIV < 1) ? 1 : DIV;
    localparam int CW      = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_EFF - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd5,
`endif
        BREAK  = 3'd4
    } state_t;

    // Output handshake: a byte is transferred on any rising edge where
    // rx_valid && rx_ready; rx_valid stays high until that transfer happens.

    state_t          state;
    logic [1:0]      sync_q;
    logic            rxs;
    logic            rxs_prev;
    logic [CW-1:0]   div_cnt;
    logic [3:0]      samp_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            deliver;
    logic            tick;
    logic            sample;
`ifdef UART_RX_PARITY_EN
    logic            parity_bad;
`endif

    assign rxs       = sync_q[1];
    assign tick      = (div_cnt == DIV_LAST);
    assign sample    = tick && (samp_cnt == 4'd7);
    assign fsm_state = state;

`ifndef UART_RX_PARITY_EN
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sync_q      <= 2'b11;
            rxs_prev    <= 1'b1;
            div_cnt     <= '0;
            samp_cnt    <= 4'd0;
            bit_idx     <= 3'd0;
            shift       <= 8'd0;
            deliver     <= 1'b0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], rxd};
            rxs_prev    <= rxs;
            deliver     <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
`endif

            // Counters sit at zero while idle, so a start edge restarts them.
            if (state == IDLE) begin
                div_cnt  <= '0;
                samp_cnt <= 4'd0;
            end else if (tick) begin
                div_cnt  <= '0;
                samp_cnt <= samp_cnt + 4'd1;
            end else begin
                div_cnt  <= div_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (rxs_prev && !rxs) state <= START;
                end
                START: begin
                    if (sample) begin
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        parity_bad <= (rxs != ^shift);
                        state      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        if (rxs) begin
                            deliver     <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // shift is stable for many cycles after the stop sample, so it is loaded directly.
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                parity_error <= parity_bad;
`endif
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit (DIV=1).
module tb_uart_receiver;

    logic       clock;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_error;
    logic       overrun;
    logic       parity_error;
    logic [2:0] fsm_state;

`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    uart_receiver #(
        .CLK_FREQ  (16_000_000),
        .BAUD_RATE (1_000_000)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .parity_error (parity_error),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // scoreboard: bytes expected to be accepted by the consumer, in order
    logic [7:0] exp_q[$];
    int acc_cnt = 0;
    int fe_cnt  = 0;
    int ovr_cnt = 0;
    int pe_cnt  = 0;

    always @(negedge clock) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: got byte 0x%0h, expected none", rx_data);
                end else begin
                    check("sb_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (frame_error)  fe_cnt++;
            if (overrun)      ovr_cnt++;
            if (parity_error) pe_cnt++;
        end
    end

    // driver tasks; every task returns 1 time unit after a rising edge
    task automatic send_bit(input logic b);
        rxd = b;
        repeat (16) @(posedge clock);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * 16) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN != 0) send_bit((^d) ^ flip);
        if (stop_ok) begin
            send_bit(1'b1);
        end else begin
            repeat (3) send_bit(1'b0);
            rxd = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       flip;
        int         exp_acc;
        int         exp_fe;
        int         exp_pe;
    } vec_t;

    vec_t vecs[7];
    int   a0, f0, o0, p0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 0, 0};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 0, 1, 0};
        vecs[4] = '{8'h12, 1'b1, 1'b0, 1, 0, 0};
        vecs[5] = '{8'h07, 1'b1, 1'b0, 1, 0, 0};
        vecs[6] = '{8'h07, 1'b1, 1'b1, 1, 0, PAR_EN};

        rst_n    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_pulses", {29'd0, frame_error, overrun, parity_error}, 32'd0);
        check("rst_state", {29'd0, fsm_state}, 32'd0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        idle_bits(1);

        // table-driven single frames with rx_ready held high
        for (int i = 0; i < 7; i++) begin
            a0 = acc_cnt; f0 = fe_cnt; o0 = ovr_cnt; p0 = pe_cnt;
            if (vecs[i].exp_acc != 0) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].flip);
            idle_bits(2);
            check($sformatf("v%0d_accepts", i), acc_cnt - a0, vecs[i].exp_acc);
            check($sformatf("v%0d_frame_err", i), fe_cnt - f0, vecs[i].exp_fe);
            check($sformatf("v%0d_overrun", i), ovr_cnt - o0, 0);
            check($sformatf("v%0d_parity_err", i), pe_cnt - p0, vecs[i].exp_pe);
            check($sformatf("v%0d_state", i), {29'd0, fsm_state}, 32'd0);
        end

        // back-to-back frames into a stalled consumer
        a0 = acc_cnt; o0 = ovr_cnt; p0 = pe_cnt;
        rx_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle_bits(1);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_accepts", acc_cnt - a0, 0);
        check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        check("ovr_data_held", {24'd0, rx_data}, 32'h3C);
        check("ovr_parity_err", pe_cnt - p0, 0);
        rx_ready = 1'b1;
        @(posedge clock);
        #1;
        check("drain_valid", {31'd0, rx_valid}, 32'd0);
        check("drain_data", {24'd0, rx_data}, 32'h3C);
        check("drain_accepts", acc_cnt - a0, 1);

        // short low glitch on an idle line
        a0 = acc_cnt; f0 = fe_cnt;
        rxd = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        rxd = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("glitch_in_start", {29'd0, fsm_state}, 32'd1);
        idle_bits(2);
        check("glitch_accepts", acc_cnt - a0, 0);
        check("glitch_frame_err", fe_cnt - f0, 0);
        check("glitch_state", {29'd0, fsm_state}, 32'd0);

        // reset in the middle of data bit 4 of 0xFF, then a clean 0x81
        a0 = acc_cnt; f0 = fe_cnt; o0 = ovr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rxd = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check("mid_frame_state", {29'd0, fsm_state}, 32'd2);
        rst_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("midrst_state", {29'd0, fsm_state}, 32'd0);
        check("midrst_data", {24'd0, rx_data}, 32'd0);
        check("midrst_valid", {31'd0, rx_valid}, 32'd0);
        rst_n = 1'b1;
        idle_bits(2);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        idle_bits(2);
        check("after_rst_accepts", acc_cnt - a0, 1);
        check("after_rst_data", {24'd0, rx_data}, 32'h81);
        check("after_rst_pulses", (fe_cnt - f0) + (ovr_cnt - o0), 0);

        check("sb_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
